rtc_alarm_bank: RTL

Parametrised multi-channel alarm engine for the BCD RTC. It runs in the rtc_clk domain next to the timekeeper and compares the current BCD date/time against NUM_ALARMS independent alarm channels. Each channel has per-field wildcard masks and a one-shot or repeat mode. Per-channel pending bits are write-1-to-clear, and a single masked interrupt with a priority-encoded channel ID is produced. Configuration uses a simple single-cycle register port; CDC to the CPU bus is done outside this block.

---
 rtl/rtc_pkg.sv | 44 ++++
 rtl/rtc_alarm_channel.sv | 75 +++++++
 rtl/rtc_alarm_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC definitions: alarm register map, ALM_CTRL bit positions and the
// BCD date/time field layout also used by the timekeeper.
package rtc_pkg;

  localparam int CH_STRIDE    = 'h10;
  localparam int OFF_ALM_DATE = 'h0;
  localparam int OFF_ALM_TIME = 'h4;
  localparam int OFF_ALM_CTRL = 'h8;
  localparam int OFF_PENDING  = 'h100;
  localparam int OFF_INT_MASK = 'h104;
  localparam int OFF_INFO     = 'h108;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_REPEAT = 1;
  localparam int FLD_SEC     = 2;
  localparam int FLD_MIN     = 3;
  localparam int FLD_HOUR    = 4;
  localparam int FLD_DAY     = 5;
  localparam int FLD_MONTH   = 6;
  localparam int FLD_YEAR    = 7;
  localparam int CTRL_W      = 8;

  // BCD layout: date = YYYYMMDD, time = 00HHMMSS
  localparam int SEC_LSB   = 0;
  localparam int MIN_LSB   = 8;
  localparam int HOUR_LSB  = 16;
  localparam int DAY_LSB   = 0;
  localparam int MONTH_LSB = 8;
  localparam int YEAR_LSB  = 16;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
  } date_t;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } time_t;

endpackage

// File: rtl/rtc_alarm_channel.sv
// One alarm channel: date/time/ctrl registers, per-field BCD comparators with
// wildcard enables, and one-shot auto-disable on match.
module rtc_alarm_channel
  import rtc_pkg::*;
(
  input  logic              rtc_clk,
  input  logic              resetn,
  input  logic [31:0]       cur_date,
  input  logic [31:0]       cur_time,
  input  logic              time_strobe,
  input  logic              wr_date,
  input  logic              wr_time,
  input  logic              wr_ctrl,
  input  logic [31:0]       wdata,
  output logic [31:0]       alm_date,
  output logic [23:0]       alm_time,
  output logic [CTRL_W-1:0] alm_ctrl,
  output logic              match
);

  logic [31:0]       date_q, date_d;
  logic [23:0]       time_q, time_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  date_t      now_date, al_date;
  time_t      now_time, al_time;
  logic [5:0] fld_eq;
  logic [5:0] fld_ok;
  logic       unused_time_rsvd;

  assign unused_time_rsvd = ^cur_time[31:24];

  always_comb begin
    now_date = date_t'(cur_date);
    now_time = time_t'(cur_time);
    al_date  = date_t'(date_q);
    al_time  = time_t'({8'h00, time_q});

    fld_eq[FLD_SEC-FLD_SEC]   = (now_time.sec   == al_time.sec);
    fld_eq[FLD_MIN-FLD_SEC]   = (now_time.min   == al_time.min);
    fld_eq[FLD_HOUR-FLD_SEC]  = (now_time.hour  == al_time.hour);
    fld_eq[FLD_DAY-FLD_SEC]   = (now_date.day   == al_date.day);
    fld_eq[FLD_MONTH-FLD_SEC] = (now_date.month == al_date.month);
    fld_eq[FLD_YEAR-FLD_SEC]  = (now_date.year  == al_date.year);

    // A disabled field is a wildcard; all-wildcard gives a 1 Hz tick.
    fld_ok = ~ctrl_q[FLD_YEAR:FLD_SEC] | fld_eq;
    match  = time_strobe & ctrl_q[CTRL_EN] & (&fld_ok);

    date_d = wr_date ? wdata : date_q;
    time_d = wr_time ? wdata[23:0] : time_q;

    ctrl_d = ctrl_q;
    if (match && !ctrl_q[CTRL_REPEAT]) ctrl_d[CTRL_EN] = 1'b0;
    // Software write lands after the auto-clear so it takes priority.
    if (wr_ctrl) ctrl_d = wdata[CTRL_W-1:0];
  end

  always_ff @(posedge rtc_clk) begin
    if (!resetn) begin
      date_q <= '0;
      time_q <= '0;
      ctrl_q <= '0;
    end else begin
      date_q <= date_d;
      time_q <= time_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign alm_date = date_q;
  assign alm_time = time_q;
  assign alm_ctrl = ctrl_q;

endmodule

// File: rtl/rtc_alarm_bank.sv
// Multi-channel RTC alarm engine: per-channel alarm units, W1C pending bits,
// interrupt mask, register read mux and lowest-index-first IRQ encoder.
module rtc_alarm_bank
  import rtc_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int ADDR_W     = 9,
  parameter int ID_W       = 4
) (
  input  logic              rtc_clk,
  input  logic              resetn,
  input  logic [31:0]       cur_date,
  input  logic [31:0]       cur_time,
  input  logic              time_strobe,
  input  logic              cfg_valid,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              irq,
  output logic [ID_W-1:0]   irq_id
);

  // Config port handshake: no ready/backpressure. Every cycle with cfg_valid=1
  // is one complete access; writes take effect on that edge, and read data is
  // on cfg_rdata for exactly the following cycle (0 after any non-read cycle).

  logic [31:0]           addr_w;
  logic                  wr_en, rd_en;
  logic [NUM_ALARMS-1:0] match_vec;
  logic [31:0]           ch_date [NUM_ALARMS];
  logic [23:0]           ch_time [NUM_ALARMS];
  logic [CTRL_W-1:0]     ch_ctrl [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [NUM_ALARMS-1:0] mask_q, mask_d;
  logic [NUM_ALARMS-1:0] active;
  logic [31:0]           rdata_q, rdata_d, rd_val;
  logic                  irq_q, irq_d;
  logic [ID_W-1:0]       irq_id_q, irq_id_d;

  assign addr_w = 32'(cfg_addr) & 32'hFFFF_FFFC;
  assign wr_en  = cfg_valid & cfg_we;
  assign rd_en  = cfg_valid & ~cfg_we;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (addr_w[31:4] == 28'(g));

    rtc_alarm_channel u_ch (
      .rtc_clk     (rtc_clk),
      .resetn      (resetn),
      .cur_date    (cur_date),
      .cur_time    (cur_time),
      .time_strobe (time_strobe),
      .wr_date     (ch_wr && (addr_w[3:0] == 4'(OFF_ALM_DATE))),
      .wr_time     (ch_wr && (addr_w[3:0] == 4'(OFF_ALM_TIME))),
      .wr_ctrl     (ch_wr && (addr_w[3:0] == 4'(OFF_ALM_CTRL))),
      .wdata       (cfg_wdata),
      .alm_date    (ch_date[g]),
      .alm_time    (ch_time[g]),
      .alm_ctrl    (ch_ctrl[g]),
      .match       (match_vec[g])
    );
  end

  always_comb begin
    // Clear first, then OR in matches, so a same-cycle match survives W1C.
    pending_d = pending_q;
    if (wr_en && addr_w == 32'(OFF_PENDING))
      pending_d = pending_q & ~cfg_wdata[NUM_ALARMS-1:0];
    pending_d = pending_d | match_vec;

    mask_d = mask_q;
    if (wr_en && addr_w == 32'(OFF_INT_MASK))
      mask_d = cfg_wdata[NUM_ALARMS-1:0];

    rd_val = '0;
    if (addr_w == 32'(OFF_PENDING))  rd_val = 32'(pending_q);
    if (addr_w == 32'(OFF_INT_MASK)) rd_val = 32'(mask_q);
    if (addr_w == 32'(OFF_INFO))     rd_val = 32'(NUM_ALARMS);
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (addr_w[31:4] == 28'(i)) begin
        if (addr_w[3:0] == 4'(OFF_ALM_DATE)) rd_val = ch_date[i];
        if (addr_w[3:0] == 4'(OFF_ALM_TIME)) rd_val = {8'h00, ch_time[i]};
        if (addr_w[3:0] == 4'(OFF_ALM_CTRL)) rd_val = 32'(ch_ctrl[i]);
      end
    end
    rdata_d = rd_en ? rd_val : 32'h0;

    active   = pending_q & ~mask_q;
    irq_d    = |active;
    irq_id_d = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (active[i]) irq_id_d = ID_W'(i);
    end
  end

  always_ff @(posedge rtc_clk) begin
    if (!resetn) begin
      pending_q <= '0;
      mask_q    <= '1;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign cfg_rdata = rdata_q;
  assign irq       = irq_q;
  assign irq_id    = irq_id_q;

endmodule
